// File: rtl/sdr_cmd_timing_chk.sv
// SDRAM command-bus protocol checker: tracks per-bank state and timers, flags
// init, tRP, tRFC, tRCD, tRAS, bank-state and mode-register violations.
module sdr_cmd_timing_chk #(
   parameter int NUM_BANKS    = 4,
   parameter int T_RP         = 2,
   parameter int T_RFC        = 7,
   parameter int T_RCD        = 2,
   parameter int T_RAS        = 4,
   parameter int INIT_NOP_CYC = 10000,
   parameter int CNT_W        = 16,
   localparam int BA_W        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                 sdram_clk,
   input  logic                 sdram_resetn,
   input  logic                 sdr_cs_n,
   input  logic                 sdr_ras_n,
   input  logic                 sdr_cas_n,
   input  logic                 sdr_we_n,
   input  logic [BA_W-1:0]      sdr_ba,
   input  logic                 sdr_addr10,
   input  logic [2:0]           sdr_addr_m,
   input  logic [2:0]           cfg_sdr_cas,
   input  logic                 sdr_init_done,
   input  logic                 chk_clr,
   output logic [6:0]           viol,
   output logic                 viol_pulse,
   output logic [CNT_W-1:0]     viol_cnt,
   output logic [NUM_BANKS-1:0] bank_open
);

   localparam int T_MAX_A = (T_RP  > T_RFC) ? T_RP  : T_RFC;
   localparam int T_MAX_B = (T_RCD > T_RAS) ? T_RCD : T_RAS;
   localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int TW      = $clog2(T_MAX + 1);
   localparam int IW      = $clog2(INIT_NOP_CYC + 1);

   localparam logic [TW-1:0] RP_L   = TW'(T_RP);
   localparam logic [TW-1:0] RFC_L  = TW'(T_RFC);
   localparam logic [TW-1:0] RCD_L  = TW'(T_RCD);
   localparam logic [TW-1:0] RAS_L  = TW'(T_RAS);
   localparam logic [TW-1:0] TMAX_L = TW'(T_MAX);
   localparam logic [TW-1:0] TONE_L = TW'(1);
   localparam logic [IW-1:0] INIT_LAST = IW'(INIT_NOP_CYC - 1);

   typedef enum logic [1:0] {
      INIT_WAIT,
      INIT_RUN,
      READY
   } state_t;

   state_t        state;
   logic [IW-1:0] init_cnt;
   logic          init_done_q;

   // Timers hold "cycles since event" and saturate at T_MAX (no pending constraint).
   logic [TW-1:0] rp_tmr  [NUM_BANKS];
   logic [TW-1:0] act_tmr [NUM_BANKS];
   logic [TW-1:0] rfc_tmr;

   logic is_nop, is_act, is_rd, is_wr, is_rdwr, is_pre, is_ref, is_lmr;
   logic [NUM_BANKS-1:0] sel;
   logic rp_any, ras_any;
   logic rp_hit, rfc_hit, rcd_hit, ras_hit, state_hit, init_hit, mode_hit;
   logic [6:0] new_viol;
   logic       fire;

   always_comb begin
      is_nop  = sdr_cs_n | (sdr_ras_n & sdr_cas_n & sdr_we_n);
      is_act  = ~sdr_cs_n & ~sdr_ras_n &  sdr_cas_n &  sdr_we_n;
      is_rd   = ~sdr_cs_n &  sdr_ras_n & ~sdr_cas_n &  sdr_we_n;
      is_wr   = ~sdr_cs_n &  sdr_ras_n & ~sdr_cas_n & ~sdr_we_n;
      is_pre  = ~sdr_cs_n & ~sdr_ras_n &  sdr_cas_n & ~sdr_we_n;
      is_ref  = ~sdr_cs_n & ~sdr_ras_n & ~sdr_cas_n &  sdr_we_n;
      is_lmr  = ~sdr_cs_n & ~sdr_ras_n & ~sdr_cas_n & ~sdr_we_n;
      is_rdwr = is_rd | is_wr;
   end

   always_comb begin
      sel     = '0;
      rp_any  = 1'b0;
      ras_any = 1'b0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         sel[b] = (sdr_ba == BA_W'(b));
         if (rp_tmr[b] < RP_L)
            rp_any = 1'b1;
         if ((sdr_addr10 || (sdr_ba == BA_W'(b))) && (act_tmr[b] < RAS_L))
            ras_any = 1'b1;
      end
   end

   always_comb begin
      rp_hit    = (is_act & (rp_tmr[sdr_ba] < RP_L)) | (is_ref & rp_any);
      rfc_hit   = ~is_nop & (rfc_tmr < RFC_L);
      rcd_hit   = is_rdwr & (act_tmr[sdr_ba] < RCD_L);
      ras_hit   = is_pre & ras_any;
      state_hit = (is_rdwr & ~bank_open[sdr_ba]) | (is_act & bank_open[sdr_ba]) |
                  (is_ref & (|bank_open));
      mode_hit  = is_lmr & (sdr_addr_m != cfg_sdr_cas);
      init_hit  = ((state == INIT_WAIT) & ~is_nop) |
                  ((state == READY) & init_done_q & ~sdr_init_done);
      if (state == INIT_WAIT)
         new_viol = {1'b0, init_hit, 5'b0};
      else
         new_viol = {mode_hit, init_hit, state_hit, ras_hit, rcd_hit, rfc_hit, rp_hit};
      fire = |new_viol;
   end

   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         state       <= INIT_WAIT;
         init_cnt    <= '0;
         init_done_q <= 1'b0;
      end else begin
         init_done_q <= sdr_init_done;
         case (state)
            INIT_WAIT: begin
               if (init_cnt == INIT_LAST)
                  state <= INIT_RUN;
               else
                  init_cnt <= init_cnt + IW'(1);
            end
            INIT_RUN: begin
               if (sdr_init_done)
                  state <= READY;
            end
            default: state <= READY;
         endcase
      end
   end

   // Bank state and timers follow every decoded command, legal or not.
   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         bank_open <= '0;
         rfc_tmr   <= TMAX_L;
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            rp_tmr[b]  <= TMAX_L;
            act_tmr[b] <= TMAX_L;
         end
      end else begin
         if (is_ref)
            rfc_tmr <= TONE_L;
         else if (rfc_tmr != TMAX_L)
            rfc_tmr <= rfc_tmr + TONE_L;
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (is_act && sel[b]) begin
               act_tmr[b]   <= TONE_L;
               bank_open[b] <= 1'b1;
            end else if (act_tmr[b] != TMAX_L) begin
               act_tmr[b] <= act_tmr[b] + TONE_L;
            end
            if ((is_pre && (sdr_addr10 || sel[b])) || (is_rdwr && sdr_addr10 && sel[b])) begin
               rp_tmr[b]    <= TONE_L;
               bank_open[b] <= 1'b0;
            end else if (rp_tmr[b] != TMAX_L) begin
               rp_tmr[b] <= rp_tmr[b] + TONE_L;
            end
         end
      end
   end

   // A violation in the same cycle as chk_clr survives the clear.
   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         viol       <= '0;
         viol_pulse <= 1'b0;
         viol_cnt   <= '0;
      end else begin
         viol_pulse <= fire;
         if (chk_clr) begin
            viol     <= new_viol;
            viol_cnt <= CNT_W'(fire);
         end else begin
            viol <= viol | new_viol;
            if (fire && !(&viol_cnt))
               viol_cnt <= viol_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_sdr_cmd_timing_chk.sv
// Table-driven bench for sdr_cmd_timing_chk: per-cycle command rows carry the
// rule mask they should raise; a scoreboard accumulates flags and counter.
module tb_sdr_cmd_timing_chk;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_LMR = 4'b0000;
   localparam logic [3:0] C_DES = 4'b1000;

   typedef struct {
      string      name;
      logic [3:0] cmd;
      logic [1:0] ba;
      logic       a10;
      logic [2:0] am;
      logic       clr;
      logic       idone;
      logic [6:0] mask;
      logic [3:0] open;
   } vec_t;

   typedef struct {
      string      name;
      logic [6:0] viol;
      logic       pulse;
      logic [3:0] cnt;
      logic [3:0] open;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
   logic [1:0] ba = '0;
   logic       a10 = 1'b0;
   logic [2:0] am = '0;
   logic [2:0] cfg_cas = 3'd3;
   logic       init_done = 1'b0;
   logic       clr = 1'b0;
   logic [6:0] viol;
   logic       viol_pulse;
   logic [3:0] viol_cnt;
   logic [3:0] bank_open;

   vec_t vecs[$];
   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [6:0] m_viol = '0;
   logic [3:0] m_cnt  = '0;

   always #5 clk = ~clk;

   sdr_cmd_timing_chk #(
      .NUM_BANKS(4), .T_RP(2), .T_RFC(7), .T_RCD(2), .T_RAS(4),
      .INIT_NOP_CYC(64), .CNT_W(4)
   ) dut (
      .sdram_clk(clk), .sdram_resetn(rst_n),
      .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
      .sdr_ba(ba), .sdr_addr10(a10), .sdr_addr_m(am), .cfg_sdr_cas(cfg_cas),
      .sdr_init_done(init_done), .chk_clr(clr),
      .viol(viol), .viol_pulse(viol_pulse), .viol_cnt(viol_cnt), .bank_open(bank_open)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic [3:0] c, input logic [1:0] b, input logic a,
                      input logic [2:0] m, input logic cl, input logic id,
                      input logic [6:0] mk, input logic [3:0] op);
      vec_t v;
      v.name = nm; v.cmd = c; v.ba = b; v.a10 = a; v.am = m;
      v.clr = cl; v.idone = id; v.mask = mk; v.open = op;
      vecs.push_back(v);
   endtask

   task automatic add_nops(input int n, input logic id, input logic [3:0] op);
      for (int i = 0; i < n; i++)
         add("nop", C_NOP, 2'd0, 1'b0, 3'd0, 1'b0, id, 7'h00, op);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      exp_t e, got;
      @(negedge clk);
      {cs_n, ras_n, cas_n, we_n} = v.cmd;
      ba = v.ba; a10 = v.a10; am = v.am; clr = v.clr; init_done = v.idone;
      m_viol = v.clr ? v.mask : (m_viol | v.mask);
      if (v.clr)
         m_cnt = (v.mask != 7'h00) ? 4'd1 : 4'd0;
      else if ((v.mask != 7'h00) && (m_cnt != 4'hF))
         m_cnt = m_cnt + 4'd1;
      e.name = $sformatf("%s[%0d]", v.name, idx);
      e.viol = m_viol; e.pulse = (v.mask != 7'h00); e.cnt = m_cnt; e.open = v.open;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      got = sbq.pop_front();
      check({got.name, ".viol"},  32'(viol),       32'(got.viol));
      check({got.name, ".pulse"}, 32'(viol_pulse), 32'(got.pulse));
      check({got.name, ".cnt"},   32'(viol_cnt),   32'(got.cnt));
      check({got.name, ".open"},  32'(bank_open),  32'(got.open));
   endtask

   task automatic check_reset_vals(input string nm);
      check({nm, ".viol"},  32'(viol),       32'h0);
      check({nm, ".pulse"}, 32'(viol_pulse), 32'h0);
      check({nm, ".cnt"},   32'(viol_cnt),   32'h0);
      check({nm, ".open"},  32'(bank_open),  32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Init window: only NOP legal; then READY sequences.
      add_nops(50, 1'b0, 4'h0);
      add("pre_in_init", C_PRE, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 7'h20, 4'h0);
      add_nops(29, 1'b0, 4'h0);
      add_nops(5, 1'b1, 4'h0);
      add("act_b1",      C_ACT, 2'd1, 1'b0, 3'd0, 1'b0, 1'b1, 7'h00, 4'h2);
      add("rd_b1_rcd",   C_RD,  2'd1, 1'b0, 3'd0, 1'b0, 1'b1, 7'h04, 4'h2);
      add("wr_b1_ok",    C_WR,  2'd1, 1'b0, 3'd0, 1'b0, 1'b1, 7'h00, 4'h2);
      add_nops(1, 1'b1, 4'h2);
      add("pre_b1_ras4", C_PRE, 2'd1, 1'b0, 3'd0, 1'b0, 1'b1, 7'h00, 4'h0);
      add_nops(2, 1'b1, 4'h0);
      add("ref_1",       C_REF, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1, 7'h00, 4'h0);
      add_nops(2, 1'b1, 4'h0);
      add("act_b0_rfc3", C_ACT, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1, 7'h02, 4'h1);
      add_nops(3, 1'b1, 4'h1);
      add("pre_b0",      C_PRE, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1, 7'h00, 4'h0);
      add_nops(1, 1'b1, 4'h0);
      add("ref_2",       C_REF, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1, 7'h00, 4'h0);
      add_nops(6, 1'b1, 4'h0);
      add("act_b0_rfc7", C_ACT, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1, 7'h00, 4'h1);
      add("act_b2",      C_ACT, 2'd2, 1'b0, 3'd0, 1'b0, 1'b1, 7'h00, 4'h5);
      add_nops(1, 1'b1, 4'h5);
      add("preall_ras",  C_PRE, 2'd0, 1'b1, 3'd0, 1'b0, 1'b1, 7'h08, 4'h0);
      add("act_b2_rp",   C_ACT, 2'd2, 1'b0, 3'd0, 1'b0, 1'b1, 7'h01, 4'h4);
      add_nops(1, 1'b1, 4'h4);
      add("rda_b2",      C_RD,  2'd2, 1'b1, 3'd0, 1'b0, 1'b1, 7'h00, 4'h0);
      add("act_b2_rpap", C_ACT, 2'd2, 1'b0, 3'd0, 1'b0, 1'b1, 7'h01, 4'h4);
      add("act_b2_open", C_ACT, 2'd2, 1'b0, 3'd0, 1'b0, 1'b1, 7'h10, 4'h4);
      add("lmr_bad",     C_LMR, 2'd0, 1'b0, 3'd2, 1'b0, 1'b1, 7'h40, 4'h4);
      add("clr_nop",     C_NOP, 2'd0, 1'b0, 3'd0, 1'b1, 1'b1, 7'h00, 4'h4);
      add("lmr_ok",      C_LMR, 2'd0, 1'b0, 3'd3, 1'b0, 1'b1, 7'h00, 4'h4);
      add("clr_and_act", C_ACT, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 7'h10, 4'h4);
      add("ref_open",    C_REF, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1, 7'h10, 4'h4);
      for (int i = 0; i < 6; i++)
         add("rd_b3_rfc",  C_RD,  2'd3, 1'b0, 3'd0, 1'b0, 1'b1, 7'h12, 4'h4);
      for (int i = 0; i < 8; i++)
         add("rd_b3_sat",  C_RD,  2'd3, 1'b0, 3'd0, 1'b0, 1'b1, 7'h10, 4'h4);
      add("deselect",    C_DES, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1, 7'h00, 4'h4);
      add("idone_drop",  C_NOP, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 7'h20, 4'h4);
      add("idone_low",   C_NOP, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 7'h00, 4'h4);

      #1;
      check_reset_vals("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < vecs.size(); i++)
         run_vec(vecs[i], i);

      // Asynchronous reset mid-operation, then INIT_WAIT must be active again.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("midreset");
      m_viol = '0;
      m_cnt  = '0;
      @(negedge clk);
      rst_n = 1'b1;
      vecs.delete();
      add_nops(5, 1'b0, 4'h0);
      add("act_after_rst", C_ACT, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 7'h20, 4'h1);
      add_nops(1, 1'b0, 4'h1);
      for (int i = 0; i < vecs.size(); i++)
         run_vec(vecs[i], i);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
